// File: rtl/sync_fifo_fwft_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft_if
// Bundles the write side, read side and status outputs of sync_fifo_fwft.
//   master : the stage using the FIFO (drives w_data/w_en/r_en, reads status)
//   slave  : the FIFO itself
// Signals:
//   w_data    write data            w_en      write request
//   w_full    FIFO full             w_afull   level >= almost-full threshold
//   r_en      read (pop) request    r_data    read data
//   r_empty   no readable word      r_aempty  level <= almost-empty threshold
//   level     words held           overflow/underflow  sticky error flags
// ---------------------------------------------------------------------------
interface sync_fifo_fwft_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 8
);
    logic [DATA_SIZE-1:0] w_data;
    logic                 w_en;
    logic                 w_full;
    logic                 w_afull;
    logic                 r_en;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_empty;
    logic                 r_aempty;
    logic [ADDR_SIZE:0]   level;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output w_data, w_en, r_en,
        input  w_full, w_afull, r_data, r_empty, r_aempty, level, overflow, underflow
    );

    modport slave (
        input  w_data, w_en, r_en,
        output w_full, w_afull, r_data, r_empty, r_aempty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock FIFO for the RGB->RGBW pixel path. Depth 2^ADDR_SIZE, all
// entries usable. Registered fill level, almost-full/almost-empty flags,
// sticky overflow/underflow, and a choice of standard or first-word-fall-
// through (FWFT) read behaviour.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   sync_fifo_fwft_if.slave (write, read and status signals)
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DATA_SIZE     = 32,
    parameter int ADDR_SIZE     = 8,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = (1 << ADDR_SIZE) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_fwft_if.slave bus
);

    localparam int             LW        = ADDR_SIZE + 1;
    localparam int             AW        = ADDR_SIZE;
    localparam int             DEPTH     = 1 << ADDR_SIZE;
    localparam logic [LW-1:0]  LP_DEPTH  = LW'(DEPTH);
    localparam logic [LW-1:0]  LP_AFULL  = LW'(AFULL_THRESH);
    localparam logic [LW-1:0]  LP_AEMPTY = LW'(AEMPTY_THRESH);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [LW-1:0]        r_memCount;
    logic [LW-1:0]        r_level;
    logic                 r_outValid;
    logic [DATA_SIZE-1:0] r_rdData;
    logic                 r_full;
    logic                 r_afull;
    logic                 r_empty;
    logic                 r_aempty;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_wrAcc;
    logic                 w_rdAcc;
    logic                 w_ramRead;
    logic                 w_outValidNext;
    logic                 w_emptyNext;
    logic [LW-1:0]        w_memCountNext;
    logic [LW-1:0]        w_levelNext;

    // Next-state bookkeeping. r_memCount counts words still in the RAM; in
    // FWFT mode one more word may sit in the output register (r_outValid),
    // and the reported level includes it. In FWFT mode the RAM is read
    // whenever the output register is free or being popped, so the read
    // address effectively runs one word ahead of the consumer.
    always_comb begin
        w_wrAcc        = bus.w_en && !r_full;
        w_rdAcc        = bus.r_en && !r_empty;
        w_ramRead      = 1'b0;
        w_outValidNext = 1'b0;
        if (FWFT) begin
            w_ramRead = (r_memCount != '0) && (!r_outValid || w_rdAcc);
            if (w_ramRead) begin
                w_outValidNext = 1'b1;
            end else if (w_rdAcc) begin
                w_outValidNext = 1'b0;
            end else begin
                w_outValidNext = r_outValid;
            end
        end else begin
            w_ramRead = w_rdAcc;
        end
        w_memCountNext = r_memCount + LW'(w_wrAcc) - LW'(w_ramRead);
        w_levelNext    = w_memCountNext + LW'(w_outValidNext);
        if (FWFT) begin
            w_emptyNext = !w_outValidNext;
        end else begin
            w_emptyNext = (w_levelNext == '0);
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && w_wrAcc) begin
            r_mem[r_wptr] <= bus.w_data;
        end
    end

    // Pointers, counters, read register and all flags. Flags are computed
    // from the next level so they always agree with level after an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_memCount  <= '0;
            r_level     <= '0;
            r_outValid  <= 1'b0;
            r_rdData    <= '0;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_ramRead) begin
                r_rdData <= r_mem[r_rptr];
                r_rptr   <= r_rptr + AW'(1);
            end
            if (bus.w_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.r_en && r_empty) begin
                r_underflow <= 1'b1;
            end
            r_memCount <= w_memCountNext;
            r_level    <= w_levelNext;
            r_outValid <= w_outValidNext;
            r_full     <= (w_levelNext == LP_DEPTH);
            r_afull    <= (w_levelNext >= LP_AFULL);
            r_empty    <= w_emptyNext;
            r_aempty   <= (w_levelNext <= LP_AEMPTY);
        end
    end

    assign bus.w_full    = r_full;
    assign bus.w_afull   = r_afull;
    assign bus.r_data    = r_rdData;
    assign bus.r_empty   = r_empty;
    assign bus.r_aempty  = r_aempty;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
// Drives a standard-mode and an FWFT-mode sync_fifo_fwft (default 256 x 32)
// and compares their outputs against constant tables, hand-written
// sequences and a queue-based reference of the FIFO contents.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

    localparam int DEPTH = 256;

    typedef struct {
        logic        rst;
        logic        wEn;
        logic [31:0] wData;
        logic        rEn;
        logic        expEmpty;
        logic [8:0]  expLevel;
        logic [31:0] expData;
        logic        expUnder;
    } vec_t;

    logic clk;
    logic sRst;
    logic fRst;

    int checks;
    int errors;

    vec_t        vecs[$];
    logic [31:0] mQ[$];
    logic [31:0] mData;
    logic        mOver;
    logic        mUnder;

    sync_fifo_fwft_if #(.DATA_SIZE(32), .ADDR_SIZE(8)) sBus ();
    sync_fifo_fwft_if #(.DATA_SIZE(32), .ADDR_SIZE(8)) fBus ();

    sync_fifo_fwft #(.DATA_SIZE(32), .ADDR_SIZE(8), .FWFT(1'b0)) dutStd (
        .clk (clk),
        .rst (sRst),
        .bus (sBus)
    );

    sync_fifo_fwft #(.DATA_SIZE(32), .ADDR_SIZE(8), .FWFT(1'b1)) dutFwft (
        .clk (clk),
        .rst (fRst),
        .bus (fBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; prints a FAIL line on mismatch.
    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rst, input logic wEn, input logic [31:0] wData,
                          input logic rEn, input logic expEmpty, input logic [8:0] expLevel,
                          input logic [31:0] expData, input logic expUnder);
        vec_t v;
        v.rst = rst; v.wEn = wEn; v.wData = wData; v.rEn = rEn;
        v.expEmpty = expEmpty; v.expLevel = expLevel; v.expData = expData; v.expUnder = expUnder;
        vecs.push_back(v);
    endtask

    // Drives one edge of the standard FIFO and updates the reference queue.
    task automatic applyStimulus(input logic rst, input logic wEn, input logic [31:0] wData,
                                 input logic rEn);
        logic wrAcc;
        logic rdAcc;
        sRst        = rst;
        sBus.w_en   = wEn;
        sBus.w_data = wData;
        sBus.r_en   = rEn;
        if (rst) begin
            mQ.delete();
            mData  = '0;
            mOver  = 1'b0;
            mUnder = 1'b0;
        end else begin
            wrAcc = wEn && (mQ.size() < DEPTH);
            rdAcc = rEn && (mQ.size() != 0);
            if (wEn && !wrAcc) mOver = 1'b1;
            if (rEn && !rdAcc) mUnder = 1'b1;
            if (rdAcc) mData = mQ.pop_front();
            if (wrAcc) mQ.push_back(wData);
        end
        @(posedge clk);
        #1;
        sRst      = 1'b0;
        sBus.w_en = 1'b0;
        sBus.r_en = 1'b0;
    endtask

    // Compares every standard-FIFO output against the reference.
    task automatic checkOutput(input string tag);
        int lvl;
        lvl = mQ.size();
        checkValue({tag, " level"},     64'(sBus.level),     64'(lvl));
        checkValue({tag, " w_full"},    64'(sBus.w_full),    64'(lvl == DEPTH));
        checkValue({tag, " w_afull"},   64'(sBus.w_afull),   64'(lvl >= 252));
        checkValue({tag, " r_empty"},   64'(sBus.r_empty),   64'(lvl == 0));
        checkValue({tag, " r_aempty"},  64'(sBus.r_aempty),  64'(lvl <= 4));
        checkValue({tag, " r_data"},    64'(sBus.r_data),    64'(mData));
        checkValue({tag, " overflow"},  64'(sBus.overflow),  64'(mOver));
        checkValue({tag, " underflow"}, 64'(sBus.underflow), 64'(mUnder));
    endtask

    task automatic fDrive(input logic rst, input logic wEn, input logic [31:0] wData, input logic rEn);
        fRst        = rst;
        fBus.w_en   = wEn;
        fBus.w_data = wData;
        fBus.r_en   = rEn;
        @(posedge clk);
        #1;
        fRst      = 1'b0;
        fBus.w_en = 1'b0;
        fBus.r_en = 1'b0;
    endtask

    task automatic fCheck(input string tag, input logic expEmpty, input logic [8:0] expLevel,
                          input logic [31:0] expData, input logic expUnder);
        checkValue({tag, " r_empty"},   64'(fBus.r_empty),   64'(expEmpty));
        checkValue({tag, " level"},     64'(fBus.level),     64'(expLevel));
        checkValue({tag, " r_data"},    64'(fBus.r_data),    64'(expData));
        checkValue({tag, " underflow"}, 64'(fBus.underflow), 64'(expUnder));
        checkValue({tag, " overflow"},  64'(fBus.overflow),  64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sRst = 1'b1; fRst = 1'b1;
        sBus.w_en = 1'b0; sBus.r_en = 1'b0; sBus.w_data = '0;
        fBus.w_en = 1'b0; fBus.r_en = 1'b0; fBus.w_data = '0;

        // Basic write/read/underflow table for the standard FIFO.
        addVec(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 9'd0, 32'd0, 1'b0);
        addVec(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 9'd1, 32'd0, 1'b0);
        addVec(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 9'd2, 32'd0, 1'b0);
        addVec(1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 9'd3, 32'd0, 1'b0);
        addVec(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 9'd4, 32'd0, 1'b0);
        addVec(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 9'd3, 32'd0, 1'b0);
        addVec(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 9'd2, 32'd1, 1'b0);
        addVec(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 9'd1, 32'd2, 1'b0);
        addVec(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 9'd0, 32'd3, 1'b0);
        addVec(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 9'd0, 32'd3, 1'b1);
        addVec(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 9'd0, 32'd3, 1'b1);
        for (int i = 0; i < vecs.size(); i++) begin
            sRst        = vecs[i].rst;
            sBus.w_en   = vecs[i].wEn;
            sBus.w_data = vecs[i].wData;
            sBus.r_en   = vecs[i].rEn;
            @(posedge clk);
            #1;
            checkValue($sformatf("t1[%0d] r_empty", i),   64'(sBus.r_empty),   64'(vecs[i].expEmpty));
            checkValue($sformatf("t1[%0d] level", i),     64'(sBus.level),     64'(vecs[i].expLevel));
            checkValue($sformatf("t1[%0d] r_data", i),    64'(sBus.r_data),    64'(vecs[i].expData));
            checkValue($sformatf("t1[%0d] underflow", i), 64'(sBus.underflow), 64'(vecs[i].expUnder));
            checkValue($sformatf("t1[%0d] overflow", i),  64'(sBus.overflow),  64'd0);
        end
        sRst = 1'b0; sBus.w_en = 1'b0; sBus.r_en = 1'b0;

        // Fill past full, refused write during an accepted read, drain.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("t2 reset");
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(i), 1'b0);
            checkOutput($sformatf("t2 wr%0d", i));
            if (i == 255) begin
                checkValue("t2 full at 256", 64'(sBus.w_full), 64'd1);
                checkValue("t2 level at 256", 64'(sBus.level), 64'd256);
            end
        end
        checkValue("t2 overflow sticky", 64'(sBus.overflow), 64'd1);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        checkOutput("t2 full rw");
        checkValue("t2 full rw level", 64'(sBus.level), 64'd255);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput($sformatf("t2 rd%0d", i));
        end
        checkValue("t2 last word", 64'(sBus.r_data), 64'd255);

        // Steady simultaneous read/write at level 10 across pointer wrap.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(1000 + i), 1'b0);
            checkOutput($sformatf("t3 fill%0d", i));
        end
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(1010 + i), 1'b1);
            checkOutput($sformatf("t3 rw%0d", i));
        end
        checkValue("t3 level held", 64'(sBus.level), 64'd10);
        checkValue("t3 last out", 64'(sBus.r_data), 64'd1299);

        // Reset in the middle of operation, then no stale data.
        for (int i = 0; i < 90; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(5000 + i), 1'b0);
        end
        checkOutput("t6 level100");
        applyStimulus(1'b1, 1'b1, 32'd99, 1'b1);
        checkOutput("t6 after rst");
        checkValue("t6 level 0", 64'(sBus.level), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'd7, 1'b0);
        checkOutput("t6 wr7");
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t6 rd7");
        checkValue("t6 data 7", 64'(sBus.r_data), 64'd7);

        // FWFT: prefetch latency, no-bubble pop, empty on last pop.
        fDrive(1'b1, 1'b0, 32'd0, 1'b0);
        fCheck("t5 reset", 1'b1, 9'd0, 32'd0, 1'b0);
        fDrive(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0);
        fCheck("t5 edgeN", 1'b1, 9'd1, 32'd0, 1'b0);
        fDrive(1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0);
        fCheck("t5 edgeN+1", 1'b0, 9'd2, 32'hA5A5_A5A5, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b1);
        fCheck("t5 pop1", 1'b0, 9'd1, 32'h5A5A_5A5A, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b1);
        fCheck("t5 pop2", 1'b1, 9'd0, 32'h5A5A_5A5A, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b1);
        fCheck("t5 underflow", 1'b1, 9'd0, 32'h5A5A_5A5A, 1'b1);

        // FWFT: pop and write together with nothing else stored.
        fDrive(1'b1, 1'b0, 32'd0, 1'b0);
        fDrive(1'b0, 1'b1, 32'h11, 1'b0);
        fCheck("f wr11", 1'b1, 9'd1, 32'd0, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b0);
        fCheck("f load11", 1'b0, 9'd1, 32'h11, 1'b0);
        fDrive(1'b0, 1'b1, 32'h22, 1'b1);
        fCheck("f rw22", 1'b1, 9'd1, 32'h11, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b0);
        fCheck("f load22", 1'b0, 9'd1, 32'h22, 1'b0);
        fDrive(1'b0, 1'b1, 32'h33, 1'b0);
        fCheck("f wr33", 1'b0, 9'd2, 32'h22, 1'b0);
        fDrive(1'b0, 1'b1, 32'h44, 1'b0);
        fCheck("f wr44", 1'b0, 9'd3, 32'h22, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b1);
        fCheck("f pop33", 1'b0, 9'd2, 32'h33, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b1);
        fCheck("f pop44", 1'b0, 9'd1, 32'h44, 1'b0);
        fDrive(1'b0, 1'b0, 32'd0, 1'b1);
        fCheck("f drained", 1'b1, 9'd0, 32'h44, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
